// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. It captures the register file operands with
// write-back bypass applied, inserts a single bubble on a load-use hazard,
// refreshes held operands from write-back while EX is stalled, and keeps
// a saturating count of the hazard bubbles it has inserted.
module id_ex_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [31:0]       id_rdata1,
  input  logic [31:0]       id_rdata2,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_en,
  input  logic [4:0]        wb_reg,
  input  logic [31:0]       wb_data,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_op1,
  output logic [31:0]       ex_op2,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              vld_p1;
  logic [31:0]       pc_p1;
  logic [4:0]        rs1_p1;
  logic [4:0]        rs2_p1;
  logic [4:0]        rd_p1;
  logic [31:0]       op1_p1;
  logic [31:0]       op2_p1;
  logic [31:0]       imm_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [CNT_W-1:0]  cnt_p1;

  logic [31:0]       byp1;
  logic [31:0]       byp2;
  logic [31:0]       snoop1;
  logic [31:0]       snoop2;

  // Write-back forwarding: register 0 is hard-wired and never forwarded.
  function automatic logic [31:0] fwd(input logic        en,
                                      input logic [4:0]  wreg,
                                      input logic [4:0]  rreg,
                                      input logic [31:0] wdata,
                                      input logic [31:0] rdata);
    return (en && (wreg == rreg) && (rreg != 5'd0)) ? wdata : rdata;
  endfunction

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign byp1   = fwd(wb_en, wb_reg, id_rs1, wb_data, id_rdata1);
  assign byp2   = fwd(wb_en, wb_reg, id_rs2, wb_data, id_rdata2);
  assign snoop1 = fwd(wb_en, wb_reg, rs1_p1, wb_data, op1_p1);
  assign snoop2 = fwd(wb_en, wb_reg, rs2_p1, wb_data, op2_p1);

  // Load in EX whose destination is read by the instruction in ID.
  assign hazard_stall = id_valid && vld_p1 && ctrl_p1[1] && (rd_p1 != 5'd0) &&
                        ((rd_p1 == id_rs1) || (rd_p1 == id_rs2));

  // ---- stage p0 (ID) -> p1 (EX) boundary ----
  // Register update with priority reset > flush > stall > bubble > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      pc_p1   <= '0;
      rs1_p1  <= '0;
      rs2_p1  <= '0;
      rd_p1   <= '0;
      op1_p1  <= '0;
      op2_p1  <= '0;
      imm_p1  <= '0;
      ctrl_p1 <= '0;
      cnt_p1  <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (ex_stall) begin
      op1_p1  <= snoop1;
      op2_p1  <= snoop2;
    end else if (hazard_stall) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      cnt_p1  <= sat_inc(cnt_p1);
    end else begin
      vld_p1  <= id_valid;
      pc_p1   <= id_pc;
      rs1_p1  <= id_rs1;
      rs2_p1  <= id_rs2;
      rd_p1   <= id_rd;
      op1_p1  <= byp1;
      op2_p1  <= byp2;
      imm_p1  <= id_imm;
      ctrl_p1 <= id_valid ? id_ctrl : '0;
    end
  end

  assign ex_valid  = vld_p1;
  assign ex_pc     = pc_p1;
  assign ex_rs1    = rs1_p1;
  assign ex_rs2    = rs2_p1;
  assign ex_rd     = rd_p1;
  assign ex_op1    = op1_p1;
  assign ex_op2    = op2_p1;
  assign ex_imm    = imm_p1;
  assign ex_ctrl   = ctrl_p1;
  assign stall_cnt = cnt_p1;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed vectors push hand-computed
// expectations, a monitor pops one per cycle and compares the DUT state.
module tb_id_ex_stage_reg;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, id_valid, wb_en, flush, ex_stall;
  logic [31:0]       id_pc, id_rdata1, id_rdata2, id_imm, wb_data;
  logic [4:0]        id_rs1, id_rs2, id_rd, wb_reg;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_valid, hazard_stall;
  logic [31:0]       ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  id_ex_stage_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
  );

  typedef struct {
    string             name;
    logic              full;
    logic              v;
    logic [31:0]       pc;
    logic [4:0]        rs1, rs2, rd;
    logic [31:0]       op1, op2, imm;
    logic [CTRL_W-1:0] ctrl;
    logic              hz;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [CTRL_W-1:0] ctrl, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic fl, input logic st);
    rst = r; id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_ctrl = ctrl;
    wb_en = we; wb_reg = wr; wb_data = wd; flush = fl; ex_stall = st;
  endtask

  task automatic push(input string name, input logic full, input logic v,
                      input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] op1, input logic [31:0] op2,
                      input logic [31:0] imm, input logic [CTRL_W-1:0] ctrl,
                      input logic hz, input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.name = name; e.full = full; e.v = v; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2;
    e.rd = rd; e.op1 = op1; e.op2 = op2; e.imm = imm; e.ctrl = ctrl;
    e.hz = hz; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, req);
    end
  endtask

  // Monitor: hazard_stall is sampled before the edge, registers after it.
  initial begin
    exp_t e;
    logic hz_s;
    forever begin
      @(negedge clk); #1;
      if (sb.size() != 0) begin
        e    = sb.pop_front();
        hz_s = hazard_stall;
        @(posedge clk); #1;
        vectors++;
        cmp(e.name, "hazard_stall", {31'd0, hz_s}, {31'd0, e.hz});
        cmp(e.name, "ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
        cmp(e.name, "ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
        cmp(e.name, "stall_cnt", 32'(stall_cnt), 32'(e.cnt));
        if (e.full) begin
          cmp(e.name, "ex_pc", ex_pc, e.pc);
          cmp(e.name, "ex_rs1", 32'(ex_rs1), 32'(e.rs1));
          cmp(e.name, "ex_rs2", 32'(ex_rs2), 32'(e.rs2));
          cmp(e.name, "ex_rd", 32'(ex_rd), 32'(e.rd));
          cmp(e.name, "ex_op1", ex_op1, e.op1);
          cmp(e.name, "ex_op2", ex_op2, e.op2);
          cmp(e.name, "ex_imm", ex_imm, e.imm);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    drive(1,1,32'h0,1,2,3,32'h1,32'h2,32'h3,8'hFF,0,0,0,0,0);
    // reset
    @(negedge clk); drive(1,1,32'h50,1,2,3,32'h1,32'h2,32'h3,8'h01,0,0,0,0,0);
    push("reset",1,0,0,0,0,0,0,0,0,0,0,0);
    // plain load, then reset mid-operation
    @(negedge clk); drive(0,1,32'h100,3,4,5,32'h11,32'h22,32'h7,8'h01,0,0,0,0,0);
    push("load",1,1,32'h100,3,4,5,32'h11,32'h22,32'h7,8'h01,0,0);
    @(negedge clk); drive(1,1,32'h100,3,4,5,32'h11,32'h22,32'h7,8'h01,0,0,0,0,0);
    push("rst_mid",1,0,0,0,0,0,0,0,0,0,0,0);
    // write-back bypass
    @(negedge clk); drive(0,1,32'h104,9,4,6,32'h5,32'h22,32'h0,8'h01,1,9,32'h1234,0,0);
    push("byp1",1,1,32'h104,9,4,6,32'h1234,32'h22,32'h0,8'h01,0,0);
    @(negedge clk); drive(0,1,32'h108,0,4,6,32'h5,32'h22,32'h0,8'h01,1,0,32'h1234,0,0);
    push("byp_r0",1,1,32'h108,0,4,6,32'h5,32'h22,32'h0,8'h01,0,0);
    @(negedge clk); drive(0,1,32'h10C,7,7,8,32'h1,32'h2,32'h0,8'h01,1,7,32'hBEEF,0,0);
    push("byp_both",1,1,32'h10C,7,7,8,32'hBEEF,32'hBEEF,32'h0,8'h01,0,0);
    @(negedge clk); drive(0,0,32'h110,1,2,3,32'h31,32'h32,32'h33,8'hFF,0,0,0,0,0);
    push("invalid",1,0,32'h110,1,2,3,32'h31,32'h32,32'h33,8'h00,0,0);
    // load-use: one bubble then the held instruction loads
    @(negedge clk); drive(0,1,32'h200,1,2,10,32'hA1,32'hA2,32'h4,8'h03,0,0,0,0,0);
    push("lu_load",1,1,32'h200,1,2,10,32'hA1,32'hA2,32'h4,8'h03,0,0);
    @(negedge clk); drive(0,1,32'h204,11,10,12,32'hB1,32'hB2,32'h0,8'h01,0,0,0,0,0);
    push("lu_bubble",0,0,0,0,0,0,0,0,0,8'h00,1,1);
    @(negedge clk);
    push("lu_after",1,1,32'h204,11,10,12,32'hB1,32'hB2,32'h0,8'h01,0,1);
    // stall with snoop refresh
    @(negedge clk); drive(0,1,32'h300,13,14,15,32'h1,32'h2,32'h3,8'h01,1,11,32'hAA,0,1);
    push("snoop1",1,1,32'h204,11,10,12,32'hAA,32'hB2,32'h0,8'h01,0,1);
    @(negedge clk); drive(0,1,32'h300,13,14,15,32'h1,32'h2,32'h3,8'h01,1,10,32'hCC,0,1);
    push("snoop2",1,1,32'h204,11,10,12,32'hAA,32'hCC,32'h0,8'h01,0,1);
    @(negedge clk); drive(0,1,32'h300,13,14,15,32'h1,32'h2,32'h3,8'h01,0,11,32'hDD,0,1);
    push("stall_hold",1,1,32'h204,11,10,12,32'hAA,32'hCC,32'h0,8'h01,0,1);
    // flush wins over stall and over a pending hazard
    @(negedge clk); drive(0,1,32'h400,1,2,10,32'hC1,32'hC2,32'h8,8'h02,0,0,0,0,0);
    push("fl_load",1,1,32'h400,1,2,10,32'hC1,32'hC2,32'h8,8'h02,0,1);
    @(negedge clk); drive(0,1,32'h404,10,3,4,32'hD1,32'hD2,32'h0,8'h01,0,0,0,1,1);
    push("flush_stall",0,0,0,0,0,0,0,0,0,8'h00,1,1);
    @(negedge clk); drive(0,1,32'h404,10,3,4,32'hD1,32'hD2,32'h0,8'h01,0,0,0,0,0);
    push("after_flush",1,1,32'h404,10,3,4,32'hD1,32'hD2,32'h0,8'h01,0,1);
    // hazard while EX stalled: hold, no count
    @(negedge clk); drive(0,1,32'h500,1,2,10,32'hE1,32'hE2,32'h0,8'h02,0,0,0,0,0);
    push("hs_load",1,1,32'h500,1,2,10,32'hE1,32'hE2,32'h0,8'h02,0,1);
    @(negedge clk); drive(0,1,32'h504,5,10,6,32'hF1,32'hF2,32'h0,8'h01,0,0,0,0,1);
    push("hz_stall",1,1,32'h500,1,2,10,32'hE1,32'hE2,32'h0,8'h02,1,1);
    @(negedge clk); drive(0,1,32'h504,5,10,6,32'hF1,32'hF2,32'h0,8'h01,0,0,0,0,0);
    push("hs_bubble",0,0,0,0,0,0,0,0,0,8'h00,1,2);
    @(negedge clk);
    push("hs_after",1,1,32'h504,5,10,6,32'hF1,32'hF2,32'h0,8'h01,0,2);
    // load to x0 never raises a hazard
    @(negedge clk); drive(0,1,32'h600,0,0,0,32'h0,32'h0,32'h0,8'h02,0,0,0,0,0);
    push("x0_load",1,1,32'h600,0,0,0,32'h0,32'h0,32'h0,8'h02,0,2);
    @(negedge clk); drive(0,1,32'h604,0,0,7,32'h71,32'h72,32'h0,8'h01,0,0,0,0,0);
    push("x0_use",1,1,32'h604,0,0,7,32'h71,32'h72,32'h0,8'h01,0,2);
    // counter saturation: self-dependent load repeats, one bubble per two cycles
    @(negedge clk); drive(1,0,32'h0,0,0,0,32'h0,32'h0,32'h0,8'h00,0,0,0,0,0);
    push("sat_reset",1,0,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i <= 34; i++) begin
      @(negedge clk); drive(0,1,32'h700,0,10,10,32'h55,32'h66,32'h0,8'h02,0,0,0,0,0);
      if (i % 2 == 1) begin
        b = ((i + 1) / 2 > 15) ? 15 : (i + 1) / 2;
        push("sat_bubble",0,0,0,0,0,0,0,0,0,8'h00,1,CNT_W'(b));
      end else begin
        b = (i / 2 > 15) ? 15 : i / 2;
        push("sat_load",1,1,32'h700,0,10,10,32'h55,32'h66,32'h0,8'h02,0,CNT_W'(b));
      end
    end
    @(negedge clk); drive(0,0,32'h0,0,0,0,32'h0,32'h0,32'h0,8'h00,0,0,0,0,0);
    repeat (4) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
